ram_port_a_arbiter: RTL and testbench
=====================================

// Module: ram_port_a_arbiter
// PURPOSE
// - Shares dual-port RAM port A (read/write) between two requesters; port B stays with the display reader.
// - Grants one requester at a time for a burst of LEN+1 beats at consecutive addresses.
// - Sequences RAM enables and returns read data with valid strobes; pulses done at burst end.
// PARAMETERS
// ADDR_SIZE  16  RAM address width
// DATA_SIZE  32  RAM data width
// LEN_W       8  burst length field width (beats = len+1, max 256)
// RD_LAT      1  RAM read latency: cycles from r_e_A high to data_out_A valid (1..4)
// PORTS
// clk            in   1          system clock, all logic on rising edge
// reset_n        in   1          asynchronous active-low reset
// req0/req1      in   1          burst request; level, held until grant
// we0/we1        in   1          1 = write burst, 0 = read burst; sampled at grant
// addr0/addr1    in   ADDR_SIZE  burst start address; sampled at grant
// len0/len1      in   LEN_W      beats-1; sampled at grant
// wdata0/wdata1  in   DATA_SIZE  write beat data; sampled when matching wready high
// gnt0/gnt1      out  1          high for whole burst (BURST+DRAIN) of that requester
// wready0/1      out  1          write beat accepted this edge; present next beat next cycle
// rdata0/rdata1  out  DATA_SIZE  read beat data
// rvalid0/1      out  1          rdata valid, one-cycle strobe per beat
// done0/done1    out  1          one-cycle pulse after last beat written/returned
// ram_addr_A     out  ADDR_SIZE  to RAM addr_A (registered)
// ram_data_in_A  out  DATA_SIZE  to RAM data_in_A (registered)
// ram_w_e_A      out  1          to RAM w_e_A (registered)
// ram_r_e_A      out  1          to RAM r_e_A (registered)
// ram_data_out_A in   DATA_SIZE  from RAM data_out_A
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, beat counter 0, read pipe empty, RR pointer = requester 0 preferred.
// - FSM IDLE -> BURST -> (DRAIN, read only) -> DONE -> IDLE.
// - IDLE: if any req, pick winner, latch we/addr/len, assert gnt next cycle, go BURST. Nothing requested: stay.
// - BURST: one beat per cycle, no stalls. Beat k: ram_addr_A <= base+k (wraps mod 2^ADDR_SIZE).
//   Write: wready_g=1 (combinational, in BURST), ram_data_in_A <= wdata_g, ram_w_e_A <= 1.
//   Read: ram_r_e_A <= 1; tag pushed into RD_LAT-deep valid pipe.
//   After beat len: write -> DONE; read -> DRAIN. ram_w_e_A/ram_r_e_A deasserted next cycle.
// - Read timing: ram_r_e_A high in cycle t -> ram_data_out_A captured at end of t+RD_LAT
//   -> rdata_g/rvalid_g high in cycle t+RD_LAT+1. Exactly len+1 rvalid strobes, in address order.
// - DRAIN: wait until valid pipe empty, then DONE.
// - DONE: done_g=1 one cycle, gnt_g drops with it, -> IDLE. Min one IDLE cycle between bursts.
// - req deasserted mid-burst: ignored, burst completes. req of loser while busy: held, served next.
// - Simultaneous req0 & req1 in IDLE: resolved by arbitration policy (see CONFIGURATION).
// - len = 0: single beat; len = 2^LEN_W-1: 256 beats, counter must not overflow early.
// - Reset mid-burst: immediate abort, all outputs 0, no done pulse, in-flight read data discarded.
// - Non-granted requester: wready/rvalid/done/gnt stay 0; rdata of that requester holds last value.
// CONFIGURATION
// - RAM_ARB_ROUND_ROBIN_EN defined: round-robin; pointer flips to the other requester at each DONE;
//   on simultaneous req, pointer-preferred requester wins.
// - Undefined: fixed priority, requester 0 always wins simultaneous req (requester 1 may starve).
// TESTING
// - Write burst: req0, we0=1, addr0=0x0010, len0=3, wdata 0xA0..0xA3 -> RAM w_e_A 4 cycles at 0x10..0x13, done0 once.
// - Read back: req1, we1=0, addr1=0x0010, len1=3 -> rvalid1 x4 with 0xA0..0xA3, first at issue+RD_LAT+1; done1 after last.
// - Contention: req0=req1=1 from reset, len=0 each -> RR: gnt0 then gnt1 then gnt0; fixed: gnt0 repeatedly.
// - Wrap: addr0=0xFFFE, len0=3 write -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
// - Reset_n low during beat 2 of len=7 read -> all outputs 0 same cycle, no done, next req1 granted cleanly.
// - RD_LAT=3 rerun of read-back -> same data/order, rvalid delayed by 2 extra cycles.

Source files
------------

// File: rtl/ram_port_a_arbiter_if.sv
// Requester and RAM port-A signal bundle for ram_port_a_arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/RAM side.
interface ram_port_a_arbiter_if #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 32,
  parameter int LEN_W     = 8
);
  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [ADDR_SIZE-1:0] addr0;
  logic [ADDR_SIZE-1:0] addr1;
  logic [LEN_W-1:0]     len0;
  logic [LEN_W-1:0]     len1;
  logic [DATA_SIZE-1:0] wdata0;
  logic [DATA_SIZE-1:0] wdata1;

  logic                 gnt0;
  logic                 gnt1;
  logic                 wready0;
  logic                 wready1;
  logic [DATA_SIZE-1:0] rdata0;
  logic [DATA_SIZE-1:0] rdata1;
  logic                 rvalid0;
  logic                 rvalid1;
  logic                 done0;
  logic                 done1;

  logic [ADDR_SIZE-1:0] ram_addr_A;
  logic [DATA_SIZE-1:0] ram_data_in_A;
  logic                 ram_w_e_A;
  logic                 ram_r_e_A;
  logic [DATA_SIZE-1:0] ram_data_out_A;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    input  ram_data_out_A,
    output gnt0, gnt1, wready0, wready1, rdata0, rdata1, rvalid0, rvalid1,
    output done0, done1,
    output ram_addr_A, ram_data_in_A, ram_w_e_A, ram_r_e_A
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    output ram_data_out_A,
    input  gnt0, gnt1, wready0, wready1, rdata0, rdata1, rvalid0, rvalid1,
    input  done0, done1,
    input  ram_addr_A, ram_data_in_A, ram_w_e_A, ram_r_e_A
  );
endinterface

// File: rtl/ram_port_a_arbiter.sv
// Shares RAM port A between two requesters in bursts of len+1 beats. RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
// Latency: gnt 1 cycle after req in IDLE; rdata/rvalid RD_LAT+1 cycles after ram_r_e_A.
// Backpressure: none inside a burst (one beat per cycle); the losing requester holds req until it is served.
module ram_port_a_arbiter #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 32,
  parameter int LEN_W     = 8,
  parameter int RD_LAT    = 1
) (
  input  logic clk,
  input  logic reset_n,
  ram_port_a_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;

  logic                 ram_we_q, ram_we_d;
  logic                 ram_re_q, ram_re_d;
  logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_SIZE-1:0] ram_din_q, ram_din_d;

  logic [RD_LAT-1:0]    vpipe_q;
  logic [DATA_SIZE-1:0] rdata0_q, rdata1_q;
  logic                 rvalid0_q, rvalid1_q;

  logic                 any_req;
  logic                 winner;
  logic                 last_beat;
  logic                 pipe_empty;
  logic                 rd_ret;
  logic                 in_burst;
  logic                 owned;
  logic [DATA_SIZE-1:0] wdata_g;

  assign any_req = bus.req0 | bus.req1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic rr_q;

  // Pointer names the preferred requester; it moves to the other side after every burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= 1'b0;
    end else if (state_q == ST_DONE) begin
      rr_q <= ~owner_q;
    end
  end

  assign winner = (bus.req0 && bus.req1) ? rr_q : bus.req1;
`else
  assign winner = ~bus.req0;
`endif

  assign last_beat  = (cnt_q == len_q);
  assign pipe_empty = ~ram_re_q && (vpipe_q == '0);
  assign rd_ret     = vpipe_q[RD_LAT-1];
  assign wdata_g    = owner_q ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ram_we_d   = 1'b0;
    ram_re_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          we_d    = winner ? bus.we1   : bus.we0;
          addr_d  = winner ? bus.addr1 : bus.addr0;
          len_d   = winner ? bus.len1  : bus.len0;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        ram_addr_d = addr_q;
        addr_d     = addr_q + ADDR_SIZE'(1);
        ram_we_d   = we_q;
        ram_re_d   = ~we_q;
        if (we_q) begin
          ram_din_d = wdata_g;
        end
        // Compare before increment so a full 2^LEN_W-beat burst never wraps the counter early.
        if (last_beat) begin
          cnt_d   = '0;
          state_d = we_q ? ST_DONE : ST_DRAIN;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end

      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ram_we_q   <= ram_we_d;
      ram_re_q   <= ram_re_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  // Valid pipe mirrors the RAM read latency; owner is stable until DONE so it routes returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      vpipe_q[0] <= ram_re_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
      end
      rvalid0_q <= rd_ret & ~owner_q;
      rvalid1_q <= rd_ret &  owner_q;
      if (rd_ret && !owner_q) begin
        rdata0_q <= bus.ram_data_out_A;
      end
      if (rd_ret && owner_q) begin
        rdata1_q <= bus.ram_data_out_A;
      end
    end
  end

  assign in_burst = (state_q == ST_BURST);
  assign owned    = (state_q == ST_BURST) || (state_q == ST_DRAIN);

  assign bus.gnt0    = owned & ~owner_q;
  assign bus.gnt1    = owned &  owner_q;
  assign bus.wready0 = in_burst & we_q & ~owner_q;
  assign bus.wready1 = in_burst & we_q &  owner_q;
  assign bus.done0   = (state_q == ST_DONE) & ~owner_q;
  assign bus.done1   = (state_q == ST_DONE) &  owner_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

  assign bus.ram_addr_A    = ram_addr_q;
  assign bus.ram_data_in_A = ram_din_q;
  assign bus.ram_w_e_A     = ram_we_q;
  assign bus.ram_r_e_A     = ram_re_q;

endmodule

// File: tb/tb_ram_port_a_arbiter.sv
// Scoreboard bench for ram_port_a_arbiter: stimulus queues expected RAM writes, reads, returns, grants and dones.
// A monitor compares them on the falling edge; a behavioural RAM with RD_LAT read latency sits on port A.
module tb_ram_port_a_arbiter;
  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int LW     = 8;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  ram_port_a_arbiter_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .LEN_W(LW)) bus();

  ram_port_a_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .LEN_W(LW), .RD_LAT(RD_LAT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [RD_LAT];

  always @(posedge clk) begin
    if (bus.ram_w_e_A) mem[bus.ram_addr_A] <= bus.ram_data_in_A;
    if (bus.ram_r_e_A) rpipe[0] <= mem[bus.ram_addr_A];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.ram_data_out_A = rpipe[RD_LAT-1];

  logic [AW+DW-1:0] wq[$];
  logic [AW-1:0]    raq[$];
  logic [DW:0]      rq[$];
  bit               gq[$];
  bit               dq[$];
  int               re_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ign_rd = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({bus.gnt0, bus.gnt1, bus.wready0, bus.wready1, bus.rvalid0, bus.rvalid1,
                            bus.done0, bus.done1, bus.ram_w_e_A, bus.ram_r_e_A}), 64'd0);
    chk({tag, "_ram_addr"}, 64'(bus.ram_addr_A), 64'd0);
    chk({tag, "_ram_din"}, 64'(bus.ram_data_in_A), 64'd0);
    chk({tag, "_rdata0"}, 64'(bus.rdata0), 64'd0);
    chk({tag, "_rdata1"}, 64'(bus.rdata1), 64'd0);
  endtask

  task automatic monitor();
    logic [AW+DW-1:0] w;
    logic [DW:0]      r;
    bit               g;
    bit               pg0 = 1'b0;
    bit               pg1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        re_cyc.delete();
        pg0 = 1'b0;
        pg1 = 1'b0;
      end else begin
        cyc++;
        if (bus.ram_w_e_A) begin
          chk("wr_expected", 64'(wq.size() != 0), 64'd1);
          if (wq.size() != 0) begin
            w = wq.pop_front();
            chk("wr_addr", 64'(bus.ram_addr_A), 64'(w[AW+DW-1:DW]));
            chk("wr_data", 64'(bus.ram_data_in_A), 64'(w[DW-1:0]));
          end
        end
        if (bus.ram_r_e_A && !ign_rd) begin
          chk("rd_expected", 64'(raq.size() != 0), 64'd1);
          if (raq.size() != 0) chk("rd_addr", 64'(bus.ram_addr_A), 64'(raq.pop_front()));
          re_cyc.push_back(cyc);
        end
        if ((bus.rvalid0 || bus.rvalid1) && !ign_rd) begin
          chk("rv_expected", 64'(rq.size() != 0), 64'd1);
          if (rq.size() != 0) begin
            r = rq.pop_front();
            chk("rv_who", 64'({bus.rvalid1, bus.rvalid0}), r[DW] ? 64'd2 : 64'd1);
            chk("rv_data", 64'(r[DW] ? bus.rdata1 : bus.rdata0), 64'(r[DW-1:0]));
          end
          if (re_cyc.size() != 0) chk("rv_latency", 64'(cyc - re_cyc.pop_front()), 64'(RD_LAT + 1));
        end
        if (bus.done0 || bus.done1) begin
          chk("done_expected", 64'(dq.size() != 0), 64'd1);
          if (dq.size() != 0) begin
            g = dq.pop_front();
            chk("done_who", 64'({bus.done1, bus.done0}), g ? 64'd2 : 64'd1);
          end
        end
        if ((bus.gnt0 && !pg0) || (bus.gnt1 && !pg1)) begin
          chk("gnt_expected", 64'(gq.size() != 0), 64'd1);
          if (gq.size() != 0) begin
            g = gq.pop_front();
            chk("gnt_who", 64'({bus.gnt1, bus.gnt0}), g ? 64'd2 : 64'd1);
          end
        end
        pg0 = bus.gnt0;
        pg1 = bus.gnt1;
      end
    end
  endtask

  task automatic set_req(input bit who, input bit v);
    if (who) bus.req1 = v; else bus.req0 = v;
  endtask

  task automatic burst(input bit who, input bit we, input logic [AW-1:0] addr,
                       input logic [LW-1:0] len, input logic [DW-1:0] dbase);
    int t;
    int k;
    gq.push_back(who);
    dq.push_back(who);
    for (int i = 0; i <= int'(len); i++) begin
      if (we) begin
        wq.push_back({addr + AW'(i), dbase + DW'(i)});
      end else begin
        raq.push_back(addr + AW'(i));
        rq.push_back({who, dbase + DW'(i)});
      end
    end
    if (who) begin
      bus.we1 = we; bus.addr1 = addr; bus.len1 = len; bus.wdata1 = dbase;
    end else begin
      bus.we0 = we; bus.addr0 = addr; bus.len0 = len; bus.wdata0 = dbase;
    end
    set_req(who, 1'b1);
    t = 0;
    while (!(who ? bus.gnt1 : bus.gnt0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("gnt_in_time", 64'(t < 40), 64'd1);
    set_req(who, 1'b0);
    // Scramble command fields: they must have been captured at grant.
    if (who) begin
      bus.we1 = ~we; bus.addr1 = ~addr; bus.len1 = ~len;
    end else begin
      bus.we0 = ~we; bus.addr0 = ~addr; bus.len0 = ~len;
    end
    k = 0;
    t = 0;
    while (!(who ? bus.done1 : bus.done0) && t < 600) begin
      if (who) bus.wdata1 = dbase + DW'(k); else bus.wdata0 = dbase + DW'(k);
      if (who ? bus.wready1 : bus.wready0) k++;
      @(negedge clk);
      t++;
    end
    chk("done_in_time", 64'(t < 600), 64'd1);
    chk("wready_count", 64'(k), we ? 64'(int'(len) + 1) : 64'd0);
    @(negedge clk);
  endtask

  task automatic contention();
    int  n;
    int  t;
    bit  p0;
    bit  p1;
    bit  order [3];
`ifdef RAM_ARB_ROUND_ROBIN_EN
    order = '{1'b0, 1'b1, 1'b0};
`else
    order = '{1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 3; i++) begin
      gq.push_back(order[i]);
      dq.push_back(order[i]);
      wq.push_back(order[i] ? {16'h0200, 32'h0000_00C1} : {16'h0100, 32'h0000_00C0});
    end
    bus.we0 = 1'b1; bus.addr0 = 16'h0100; bus.len0 = '0; bus.wdata0 = 32'h0000_00C0;
    bus.we1 = 1'b1; bus.addr1 = 16'h0200; bus.len1 = '0; bus.wdata1 = 32'h0000_00C1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    n = 0; t = 0; p0 = 1'b0; p1 = 1'b0;
    while (n < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if ((bus.gnt0 && !p0) || (bus.gnt1 && !p1)) n++;
      p0 = bus.gnt0;
      p1 = bus.gnt1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("contention_grants", 64'(n), 64'd3);
    repeat (4) @(negedge clk);
  endtask

  task automatic abort_read();
    int t;
    ign_rd = 1'b1;
    gq.push_back(1'b1);
    bus.we1 = 1'b0; bus.addr1 = 16'h0010; bus.len1 = 8'd7;
    bus.req1 = 1'b1;
    t = 0;
    while (!bus.gnt1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("abort_gnt_in_time", 64'(t < 40), 64'd1);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_zero("abort");
    ign_rd = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic stim();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    contention();
    burst(1'b0, 1'b1, 16'h0010, 8'd3, 32'h0000_00A0);
    burst(1'b1, 1'b0, 16'h0010, 8'd3, 32'h0000_00A0);
    chk("rdata0_hold", 64'(bus.rdata0), 64'd0);
    burst(1'b0, 1'b1, 16'hFFFE, 8'd3, 32'h0000_00B0);
    burst(1'b0, 1'b0, 16'hFFFE, 8'd3, 32'h0000_00B0);
    burst(1'b0, 1'b1, 16'h1000, 8'hFF, 32'h0000_5000);
    burst(1'b1, 1'b0, 16'h1000, 8'hFF, 32'h0000_5000);
    chk("rdata0_hold_b3", 64'(bus.rdata0), 64'h0000_00B3);
    abort_read();
    burst(1'b1, 1'b0, 16'h0010, 8'd3, 32'h0000_00A0);
    repeat (RD_LAT + 4) @(negedge clk);

    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("raq_drained", 64'(raq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("gq_drained", 64'(gq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    stim();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
